ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  EX stage plus EX/MEM pipeline register. Sits directly downstream of the ID/EX register.
//  - Forwards operands, decodes ALUOp/funct and executes the ALU op.
//  - Computes the branch target.
//  - Registers results and the WB/M controls toward MEM.
//  - Optional iterative shift-add multiplier: stalls the pipe while it runs.
// PARAMETERS
//  DATA_W  32  datapath width
//  MUL_K   1   multiplier bits retired per cycle (1,2,4); run length = DATA_W/MUL_K cycles
// PORTS
//  clk_i           in   1       clock, rising edge
//  rst_i           in   1       synchronous reset, active-high
//  RegWrite_i      in   1       WB control from ID/EX
//  MemtoReg_i      in   1       WB control from ID/EX
//  Branch_i        in   1       M control from ID/EX
//  MemRead_i       in   1       M control from ID/EX
//  MemWrite_i      in   1       M control from ID/EX
//  RegDst_i        in   1       1: dest=rd_addr_i, 0: dest=rt_addr_i
//  ALUOp_i         in   2       00 add, 01 sub, 10 R-type (funct), 11 or
//  ALUSrc_i        in   1       1: operand B = Sign_Extend_i
//  addr_i          in   DATA_W  PC+4 of instruction
//  RSdata_i        in   DATA_W  rs register data
//  RTdata_i        in   DATA_W  rt register data
//  Sign_Extend_i   in   DATA_W  immediate; [5:0] = funct
//  rt_addr_i       in   5       instr[20:16]
//  rd_addr_i       in   5       instr[15:11]
//  fwdA_i          in   2       00 RSdata, 01 wb_data_i, 10 mem_data_i, 11 reserved (=00)
//  fwdB_i          in   2       same encoding, applied to RTdata
//  mem_data_i      in   DATA_W  forwarded EX/MEM result
//  wb_data_i       in   DATA_W  forwarded MEM/WB result
//  stall_o         out  1       1: upstream (PC, IF/ID, ID/EX) must hold
//  RegWrite_o      out  1       registered WB control
//  MemtoReg_o      out  1       registered WB control
//  Branch_o        out  1       registered M control
//  MemRead_o       out  1       registered M control
//  MemWrite_o      out  1       registered M control
//  ALUResult_o     out  DATA_W  registered ALU/multiplier result
//  Zero_o          out  1       registered (ALUResult==0)
//  WriteData_o     out  DATA_W  registered forwarded rt value (store data)
//  WBaddr_o        out  5       registered destination register
//  BranchAddr_o    out  DATA_W  registered addr_i + (Sign_Extend_i<<2)
// BEHAVIOUR
//  - Reset (rst_i=1 at posedge): every registered output = 0, stall_o=0, FSM->IDLE. Overrides any run in progress.
//  - Funct decode (ALUOp=10): 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed, result 0/1), 0x18 mul.
//  - Undefined funct: add.
//  - Arithmetic: add/sub wrap mod 2^DATA_W, no overflow trap. Mul keeps low DATA_W bits of the product.
//  - Non-mul ops: 1-cycle latency, result registered on the next posedge; stall_o=0.
//  - FSM states: IDLE, RUN, DONE.
//  - IDLE -> RUN on a mul instruction with RegWrite_i=1. Operands are latched; counter = DATA_W/MUL_K.
//  - In RUN and IDLE->RUN transition cycle: stall_o=1 combinationally. EX/MEM gets a bubble (all controls 0).
//  - Upstream holds ID/EX stable while stall_o=1.
//  - RUN: each cycle adds MUL_K partial products, counter decrements; counter hits 0 -> DONE.
//  - DONE: stall_o=0. The mul result and its controls are registered into EX/MEM. -> IDLE.
//  - Total: a mul occupies DATA_W/MUL_K+1 cycles in EX.
//  - Mul with RegWrite_i=0 (bubble) does not start the FSM.
//  - Forwarding mux selection is sampled every cycle. During RUN the latched operands are used, not live inputs.
//  - Zero_o, BranchAddr_o register every non-stalled cycle regardless of Branch_i.
// CONFIGURATION
//  EX_MUL_EN defined:   multiplier and FSM are built as above.
//  EX_MUL_EN undefined: funct 0x18 is decoded as add; FSM absent; stall_o is tied to 0.
// TESTING
//  1 rst_i=1 mid-RUN -> next cycle all outputs 0, stall_o=0; following add executes normally.
//  2 ALUOp=10, funct 0x2A, rs=0xFFFFFFFF, rt=1 -> ALUResult_o=1 next cycle; Zero_o=0.
//  3 ALUOp=01, rs=rt=5, imm=3, addr=0x100 -> ALUResult_o=0, Zero_o=1, BranchAddr_o=0x10C.
//  4 fwdA=10, mem_data=7; fwdB=01, wb_data=9; ALUOp=00 -> ALUResult_o=16; WriteData_o=9.
//  5 EX_MUL_EN, MUL_K=1: mul 0x10000*0x10003 -> stall_o high 32 cycles, bubbles out.
//    Then ALUResult_o=0x00030000, RegWrite_o=1, WBaddr_o=rd.
//  6 Without EX_MUL_EN: funct 0x18, rs=3, rt=4 -> ALUResult_o=7, stall_o never asserted.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: execute stage followed by the EX/MEM pipeline register.
// Selects forwarded operands, decodes ALUOp/funct, runs the ALU, computes the
// branch target and registers results plus WB/M controls toward MEM.
// Build option EX_MUL_EN: adds an iterative shift-add multiplier (funct 0x18)
// that stalls upstream while it runs. Without it, funct 0x18 executes as add
// and stall_o is tied low.
module ex_stage #(
  parameter int DATA_W = 32,
  parameter int MUL_K  = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic              Branch_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              RegDst_i,
  input  logic [1:0]        ALUOp_i,
  input  logic              ALUSrc_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] RSdata_i,
  input  logic [DATA_W-1:0] RTdata_i,
  input  logic [DATA_W-1:0] Sign_Extend_i,
  input  logic [4:0]        rt_addr_i,
  input  logic [4:0]        rd_addr_i,
  input  logic [1:0]        fwdA_i,
  input  logic [1:0]        fwdB_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              stall_o,
  output logic              RegWrite_o,
  output logic              MemtoReg_o,
  output logic              Branch_o,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic [DATA_W-1:0] ALUResult_o,
  output logic              Zero_o,
  output logic [DATA_W-1:0] WriteData_o,
  output logic [4:0]        WBaddr_o,
  output logic [DATA_W-1:0] BranchAddr_o
);

  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL} alu_op_e;

  alu_op_e           op;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] store_data;
  logic [4:0]        dest_addr;
  logic              stall;

  logic              reg_write_q;
  logic              mem_to_reg_q;
  logic              branch_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [DATA_W-1:0] alu_res_q;
  logic              zero_q;
  logic [DATA_W-1:0] write_data_q;
  logic [4:0]        wb_addr_q;
  logic [DATA_W-1:0] branch_addr_q;

  // Operand forwarding; code 11 is reserved and falls back to register data
  always_comb begin
    case (fwdA_i)
      2'b01:   op_a = wb_data_i;
      2'b10:   op_a = mem_data_i;
      default: op_a = RSdata_i;
    endcase
    case (fwdB_i)
      2'b01:   op_b = wb_data_i;
      2'b10:   op_b = mem_data_i;
      default: op_b = RTdata_i;
    endcase
  end

  assign alu_b     = ALUSrc_i ? Sign_Extend_i : op_b;
  assign dest_addr = RegDst_i ? rd_addr_i : rt_addr_i;

  // ALUOp/funct decode; unknown functs execute as add
  always_comb begin
    op = OP_ADD;
    case (ALUOp_i)
      2'b00: op = OP_ADD;
      2'b01: op = OP_SUB;
      2'b11: op = OP_OR;
      default: begin
        case (Sign_Extend_i[5:0])
          6'h20:   op = OP_ADD;
          6'h22:   op = OP_SUB;
          6'h24:   op = OP_AND;
          6'h25:   op = OP_OR;
          6'h2A:   op = OP_SLT;
`ifdef EX_MUL_EN
          6'h18:   op = OP_MUL;
`endif
          default: op = OP_ADD;
        endcase
      end
    endcase
  end

`ifdef EX_MUL_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam int STEPS = DATA_W / MUL_K;
  localparam int CNT_W = $clog2(STEPS);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              mul_start;

  // One multiplier step: add MUL_K partial products of the low multiplier bits
  function automatic logic [DATA_W-1:0] mul_step(input logic [DATA_W-1:0] acc,
                                                 input logic [DATA_W-1:0] mcand,
                                                 input logic [DATA_W-1:0] mplier);
    logic [DATA_W-1:0] sum;
    sum = acc;
    for (int k = 0; k < MUL_K; k++) begin
      if (mplier[k]) sum = sum + (mcand << k);
    end
    return sum;
  endfunction

  // A bubble mul (RegWrite low) never starts the multiplier
  assign mul_start = (op == OP_MUL) && RegWrite_i;

  // Multiplier FSM: the start cycle already retires the first step, so the
  // counter covers only the remaining STEPS-1 RUN cycles
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    wdata_d  = wdata_q;
    stall    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mul_start) begin
          stall    = 1'b1;
          acc_d    = mul_step('0, op_a, alu_b);
          mcand_d  = op_a << MUL_K;
          mplier_d = alu_b >> MUL_K;
          wdata_d  = op_b;
          cnt_d    = CNT_W'(STEPS - 1);
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        stall    = 1'b1;
        acc_d    = mul_step(acc_q, mcand_q, mplier_q);
        mcand_d  = mcand_q << MUL_K;
        mplier_d = mplier_q >> MUL_K;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Multiplier state and latched operands
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      wdata_q  <= wdata_d;
    end
  end

  // Store data of a finished mul comes from the value latched at start
  assign store_data = (state_q == S_DONE) ? wdata_q : op_b;
  assign stall_o    = stall & ~rst_i;
`else
  assign stall      = 1'b0;
  assign store_data = op_b;
  assign stall_o    = 1'b0;
`endif

  // ALU; wrap-around arithmetic, slt is signed
  always_comb begin
    alu_res = op_a + alu_b;
    case (op)
      OP_SUB: alu_res = op_a - alu_b;
      OP_AND: alu_res = op_a & alu_b;
      OP_OR:  alu_res = op_a | alu_b;
      OP_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(alu_b))};
`ifdef EX_MUL_EN
      OP_MUL: alu_res = acc_q;
`endif
      default: alu_res = op_a + alu_b;
    endcase
  end

  // EX/MEM register: controls become a bubble while stalled, data holds
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      reg_write_q   <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      branch_q      <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      alu_res_q     <= '0;
      zero_q        <= 1'b0;
      write_data_q  <= '0;
      wb_addr_q     <= '0;
      branch_addr_q <= '0;
    end else if (stall) begin
      reg_write_q   <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      branch_q      <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
    end else begin
      reg_write_q   <= RegWrite_i;
      mem_to_reg_q  <= MemtoReg_i;
      branch_q      <= Branch_i;
      mem_read_q    <= MemRead_i;
      mem_write_q   <= MemWrite_i;
      alu_res_q     <= alu_res;
      zero_q        <= (alu_res == '0);
      write_data_q  <= store_data;
      wb_addr_q     <= dest_addr;
      branch_addr_q <= addr_i + (Sign_Extend_i << 2);
    end
  end

  assign RegWrite_o   = reg_write_q;
  assign MemtoReg_o   = mem_to_reg_q;
  assign Branch_o     = branch_q;
  assign MemRead_o    = mem_read_q;
  assign MemWrite_o   = mem_write_q;
  assign ALUResult_o  = alu_res_q;
  assign Zero_o       = zero_q;
  assign WriteData_o  = write_data_q;
  assign WBaddr_o     = wb_addr_q;
  assign BranchAddr_o = branch_addr_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed vectors for ex_stage with a behavioural model that is
// compared against the EX/MEM outputs every cycle, plus literal spot checks.
`timescale 1ns/1ps
module tb_ex_stage;
  localparam int STEPS = 32;  // stall cycles of one mul with DATA_W=32, MUL_K=1
`ifdef EX_MUL_EN
  localparam bit MUL_BUILT = 1'b1;
`else
  localparam bit MUL_BUILT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic RegWrite, MemtoReg, Branch, MemRead, MemWrite, RegDst, ALUSrc;
  logic [1:0] ALUOp, fwdA, fwdB;
  logic [31:0] addr, rs, rt, imm, mem_data, wb_data;
  logic [4:0] rt_addr, rd_addr;

  logic stall_o, RegWrite_o, MemtoReg_o, Branch_o, MemRead_o, MemWrite_o, Zero_o;
  logic [31:0] ALUResult_o, WriteData_o, BranchAddr_o;
  logic [4:0] WBaddr_o;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk_i(clk), .rst_i(rst),
    .RegWrite_i(RegWrite), .MemtoReg_i(MemtoReg), .Branch_i(Branch),
    .MemRead_i(MemRead), .MemWrite_i(MemWrite), .RegDst_i(RegDst),
    .ALUOp_i(ALUOp), .ALUSrc_i(ALUSrc), .addr_i(addr),
    .RSdata_i(rs), .RTdata_i(rt), .Sign_Extend_i(imm),
    .rt_addr_i(rt_addr), .rd_addr_i(rd_addr),
    .fwdA_i(fwdA), .fwdB_i(fwdB), .mem_data_i(mem_data), .wb_data_i(wb_data),
    .stall_o(stall_o), .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o),
    .Branch_o(Branch_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
    .ALUResult_o(ALUResult_o), .Zero_o(Zero_o), .WriteData_o(WriteData_o),
    .WBaddr_o(WBaddr_o), .BranchAddr_o(BranchAddr_o)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] regv,
                                       input logic [31:0] wbv, input logic [31:0] memv);
    if (sel == 2'b01) return wbv;
    if (sel == 2'b10) return memv;
    return regv;
  endfunction

  function automatic logic [31:0] model_alu(input logic [1:0] aluop, input logic [5:0] funct,
                                            input logic [31:0] a, input logic [31:0] b);
    if (aluop == 2'b00) return a + b;
    if (aluop == 2'b01) return a - b;
    if (aluop == 2'b11) return a | b;
    case (funct)
      6'h22: return a - b;
      6'h24: return a & b;
      6'h25: return a | b;
      6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return a + b;
    endcase
  endfunction

  logic m_rw, m_mtr, m_br, m_mr, m_mw, m_zero;
  logic [31:0] m_res, m_wd, m_ba;
  logic [4:0] m_wb;
  bit m_res_ok, m_valid, chk_en;
  int mstate = 0;       // 0 idle, 1 mul in progress, 2 mul result due at next edge
  int left = 0;         // stall cycles still owed by the running mul
  logic [31:0] p_res, p_wd;

  function automatic bit mul_request();
    return MUL_BUILT && ALUOp == 2'b10 && imm[5:0] == 6'h18 && RegWrite;
  endfunction

  always @(posedge clk) begin : model
    logic [31:0] a, bs, b, r;
    a  = pick(fwdA, rs, wb_data, mem_data);
    bs = pick(fwdB, rt, wb_data, mem_data);
    b  = ALUSrc ? imm : bs;
    if (rst) begin
      {m_rw, m_mtr, m_br, m_mr, m_mw, m_zero} = '0;
      m_res = '0; m_wd = '0; m_ba = '0; m_wb = '0;
      m_res_ok = 1; m_valid = 1; chk_en = 1; mstate = 0;
    end else if (mstate == 1 || (mstate == 0 && mul_request())) begin
      if (mstate == 0) begin
        p_res = a * b;
        p_wd  = bs;
        left  = STEPS;
      end
      left--;
      mstate = (left == 0) ? 2 : 1;
      {m_rw, m_mtr, m_br, m_mr, m_mw} = '0;
      m_valid = 0;
    end else begin
      r = (mstate == 2) ? p_res : model_alu(ALUOp, imm[5:0], a, b);
      m_rw = RegWrite; m_mtr = MemtoReg; m_br = Branch; m_mr = MemRead; m_mw = MemWrite;
      m_res = r; m_zero = (r == 32'd0);
      m_wd = (mstate == 2) ? p_wd : bs;
      m_wb = RegDst ? rd_addr : rt_addr;
      m_ba = addr + (imm << 2);
      m_valid = 1;
      // a non-writing mul is a bubble whose result value is unspecified
      m_res_ok = !(MUL_BUILT && mstate == 0 && ALUOp == 2'b10 && imm[5:0] == 6'h18);
      mstate = 0;
    end
  end

  // compare process: every cycle on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall_o", 32'(stall_o), 32'(!rst && (mstate == 1 || (mstate == 0 && mul_request()))));
      check("RegWrite_o", 32'(RegWrite_o), 32'(m_rw));
      check("MemtoReg_o", 32'(MemtoReg_o), 32'(m_mtr));
      check("Branch_o", 32'(Branch_o), 32'(m_br));
      check("MemRead_o", 32'(MemRead_o), 32'(m_mr));
      check("MemWrite_o", 32'(MemWrite_o), 32'(m_mw));
      check("BranchAddr_o", BranchAddr_o, m_ba);
      if (m_res_ok) begin
        check("ALUResult_o", ALUResult_o, m_res);
        check("Zero_o", 32'(Zero_o), 32'(m_zero));
      end
      if (m_valid) begin
        check("WriteData_o", WriteData_o, m_wd);
        check("WBaddr_o", 32'(WBaddr_o), 32'(m_wb));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // ctrl = {RegWrite, MemtoReg, Branch, MemRead, MemWrite, RegDst}
  task automatic issue(input string name, input logic [5:0] ctrl, input logic [1:0] aluop,
                       input logic alusrc, input logic [31:0] a_v, input logic [31:0] rs_v,
                       input logic [31:0] rt_v, input logic [31:0] imm_v,
                       input logic [1:0] fa, input logic [1:0] fb,
                       input logic [31:0] memd, input logic [31:0] wbd);
    {RegWrite, MemtoReg, Branch, MemRead, MemWrite, RegDst} = ctrl;
    ALUOp = aluop; ALUSrc = alusrc; addr = a_v; rs = rs_v; rt = rt_v; imm = imm_v;
    fwdA = fa; fwdB = fb; mem_data = memd; wb_data = wbd;
    rt_addr = 5'd2; rd_addr = 5'd3;
    $display("[TB] issue %s", name);
    #1;
  endtask

  localparam logic [5:0] C_R   = 6'b100001;  // R-type writing rd
  localparam logic [5:0] C_BR  = 6'b001000;  // branch
  localparam logic [5:0] C_SW  = 6'b000010;  // store

  initial begin
    int n;
    issue("nop", 6'b0, 2'b00, 1'b0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    repeat (2) cycle();
    check("reset_ALUResult", ALUResult_o, 32'h0);
    check("reset_RegWrite", 32'(RegWrite_o), 32'h0);
    check("reset_BranchAddr", BranchAddr_o, 32'h0);
    check("reset_stall", 32'(stall_o), 32'h0);
    rst = 1'b0;

    issue("slt", C_R, 2'b10, 1'b0, 32'h40, 32'hFFFF_FFFF, 32'h1, 32'h2A, 2'b00, 2'b00, 0, 0);
    cycle();
    check("slt_result", ALUResult_o, 32'h1);
    check("slt_zero", 32'(Zero_o), 32'h0);
    check("slt_wbaddr", 32'(WBaddr_o), 32'd3);

    issue("beq_sub", C_BR, 2'b01, 1'b0, 32'h100, 32'd5, 32'd5, 32'd3, 2'b00, 2'b00, 0, 0);
    cycle();
    check("beq_result", ALUResult_o, 32'h0);
    check("beq_zero", 32'(Zero_o), 32'h1);
    check("beq_target", BranchAddr_o, 32'h10C);

    issue("fwd_add", C_R, 2'b00, 1'b0, 0, 32'd100, 32'd200, 0, 2'b10, 2'b01, 32'd7, 32'd9);
    cycle();
    check("fwd_result", ALUResult_o, 32'd16);
    check("fwd_writedata", WriteData_o, 32'd9);

    issue("and", C_R, 2'b10, 1'b0, 0, 32'h0000_F0F0, 32'h0000_FF00, 32'h24, 2'b00, 2'b00, 0, 0);
    cycle();
    check("and_result", ALUResult_o, 32'h0000_F000);
    issue("ori", C_R, 2'b11, 1'b1, 0, 32'hF0, 32'h5, 32'h0F, 2'b00, 2'b00, 0, 0);
    cycle();
    check("ori_result", ALUResult_o, 32'hFF);
    issue("sub_wrap", C_R, 2'b10, 1'b0, 32'h200, 32'h0, 32'h1, 32'h22, 2'b00, 2'b00, 0, 0);
    cycle();
    check("sub_wrap_result", ALUResult_o, 32'hFFFF_FFFF);
    issue("undef_funct_rsvfwd", C_R, 2'b10, 1'b0, 0, 32'd2, 32'd3, 32'h3F, 2'b11, 2'b11, 32'd50, 32'd60);
    cycle();
    check("undef_result", ALUResult_o, 32'd5);
    issue("add_wrap_or", C_R, 2'b10, 1'b0, 0, 32'hFFFF_FFFF, 32'd1, 32'h20, 2'b00, 2'b00, 0, 0);
    cycle();
    check("add_wrap_zero", 32'(Zero_o), 32'h1);
    issue("sw", C_SW, 2'b00, 1'b1, 32'h200, 32'h1000, 32'hABCD, 32'hFFFF_FFFF, 2'b00, 2'b00, 0, 0);
    cycle();
    check("sw_addr", ALUResult_o, 32'h0FFF);
    check("sw_target", BranchAddr_o, 32'h1FC);
    check("sw_wbaddr", 32'(WBaddr_o), 32'd2);
    check("sw_memwrite", 32'(MemWrite_o), 32'h1);

`ifdef EX_MUL_EN
    issue("mul_bubble", 6'b000001, 2'b10, 1'b0, 0, 32'd3, 32'd4, 32'h18, 2'b00, 2'b00, 0, 0);
    check("mul_bubble_stall", 32'(stall_o), 32'h0);
    cycle();
    issue("mul", C_R, 2'b10, 1'b0, 0, 32'h0001_0000, 32'h0001_0003, 32'h18, 2'b00, 2'b00, 0, 0);
    n = 0;
    while (stall_o && n < 100) begin
      cycle();
      n++;
      if (n == 5) check("mul_bubble_regwrite", 32'(RegWrite_o), 32'h0);
    end
    check("mul_stall_cycles", 32'(n), 32'(STEPS));
    cycle();
    check("mul_result", ALUResult_o, 32'h0003_0000);
    check("mul_regwrite", 32'(RegWrite_o), 32'h1);
    check("mul_wbaddr", 32'(WBaddr_o), 32'd3);
    issue("mul_reset", C_R, 2'b10, 1'b0, 0, 32'd6, 32'd7, 32'h18, 2'b00, 2'b00, 0, 0);
    repeat (5) cycle();
    check("midrun_stall", 32'(stall_o), 32'h1);
    issue("add_after_reset", C_R, 2'b00, 1'b0, 0, 32'd10, 32'd20, 0, 2'b00, 2'b00, 0, 0);
    rst = 1'b1;
    #1;
    check("reset_stall_comb", 32'(stall_o), 32'h0);
`else
    issue("funct18_as_add", C_R, 2'b10, 1'b0, 0, 32'd3, 32'd4, 32'h18, 2'b00, 2'b00, 0, 0);
    check("funct18_stall", 32'(stall_o), 32'h0);
    cycle();
    check("funct18_result", ALUResult_o, 32'd7);
    issue("add_after_reset", C_R, 2'b00, 1'b0, 0, 32'd10, 32'd20, 0, 2'b00, 2'b00, 0, 0);
    rst = 1'b1;
`endif
    cycle();
    check("midreset_ALUResult", ALUResult_o, 32'h0);
    check("midreset_RegWrite", 32'(RegWrite_o), 32'h0);
    check("midreset_stall", 32'(stall_o), 32'h0);
    rst = 1'b0;
    cycle();
    check("post_reset_add", ALUResult_o, 32'd30);
    check("post_reset_regwrite", 32'(RegWrite_o), 32'h1);
    issue("nop", 6'b0, 2'b00, 1'b0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    repeat (2) cycle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, %0d tests run", tests);
    $fatal(1, "timeout");
  end

endmodule
